// File: rtl/bird_datapath.sv
// Bird vertical motion, bounds/pipe collision and optional pipe-pass score (BIRD_SCORE_EN).
// Motion registers update one cycle after a tick; start and reset reload the launch state.
module bird_datapath #(
    parameter int SCREEN_H  = 120,
    parameter int BIRD_X    = 40,
    parameter int BIRD_SIZE = 4,
    parameter int START_Y   = 60,
    parameter int GRAVITY   = 1,
    parameter int FLAP_VEL  = 4,
    parameter int VMAX      = 6,
    parameter int PIPE_W    = 8,
    parameter int GAP_H     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       raise,
    input  logic       tick,
    input  logic [7:0] pipe_x,
    input  logic [6:0] gap_y,
    output logic [6:0] bird_y,
    output logic [4:0] vel,
    output logic       touched,
    output logic       flying,
    output logic [7:0] score
);
    typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT} state_t;

    localparam logic signed [5:0] GRAV6 = 6'(GRAVITY);
    localparam logic signed [5:0] VMAX6 = 6'(VMAX);
    localparam logic signed [4:0] FLAP5 = 5'(-FLAP_VEL);
    localparam logic signed [8:0] YMAX9 = 9'(SCREEN_H - BIRD_SIZE);

    state_t            r_state, w_state_n;
    logic [6:0]        r_bird_y;
    logic signed [4:0] r_vel;
    logic              r_touched;
    logic              w_load, w_move;
    logic signed [5:0] w_vel_inc;
    logic signed [4:0] w_vel_n;
    logic signed [8:0] w_y_raw;
    logic [6:0]        w_y_n;
    logic [8:0]        w_px9;
    logic              w_overlap, w_gap_miss, w_hit;

    // Velocity first, then position from the new velocity, then collision on the clamped row.
    always_comb begin
        w_vel_inc = {r_vel[4], r_vel} + GRAV6;
        if (raise)
            w_vel_n = FLAP5;
        else if (w_vel_inc > VMAX6)
            w_vel_n = VMAX6[4:0];
        else
            w_vel_n = w_vel_inc[4:0];
        w_y_raw = $signed({2'b00, r_bird_y}) + $signed({{4{w_vel_n[4]}}, w_vel_n});
        if (w_y_raw < 0)
            w_y_n = 7'd0;
        else if (w_y_raw > YMAX9)
            w_y_n = YMAX9[6:0];
        else
            w_y_n = w_y_raw[6:0];
        w_px9      = {1'b0, pipe_x};
        w_overlap  = (w_px9 <= 9'(BIRD_X + BIRD_SIZE - 1)) &&
                     (w_px9 + 9'(PIPE_W - 1) >= 9'(BIRD_X));
        w_gap_miss = ({2'b00, w_y_n} < {2'b00, gap_y}) ||
                     ({2'b00, w_y_n} + 9'(BIRD_SIZE) > {2'b00, gap_y} + 9'(GAP_H));
        w_hit      = (w_y_raw <= 0) || (w_y_raw >= YMAX9) || (w_overlap && w_gap_miss);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end

    // start outranks tick in every state, so a same-cycle tick produces no motion.
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_move    = 1'b0;
        case (r_state)
            S_IDLE, S_HIT: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_n = S_FLY;
                end
            end
            S_FLY: begin
                if (start) begin
                    w_load = 1'b1;
                end else if (tick) begin
                    w_move = 1'b1;
                    if (w_hit)
                        w_state_n = S_HIT;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_bird_y  <= 7'(START_Y);
            r_vel     <= 5'sd0;
            r_touched <= 1'b0;
        end else if (w_move) begin
            r_bird_y  <= w_y_n;
            r_vel     <= w_vel_n;
            r_touched <= w_hit;
        end
    end

`ifdef BIRD_SCORE_EN
    logic [7:0] r_score;

    // A pipe counts as passed on the tick its right edge lines up with the bird's left column.
    always_ff @(posedge clk) begin
        if (reset || w_load)
            r_score <= 8'd0;
        else if (w_move && !w_hit && (w_px9 + 9'(PIPE_W) == 9'(BIRD_X)) && (r_score != 8'hFF))
            r_score <= r_score + 8'd1;
    end

    assign score = r_score;
`else
    assign score = 8'd0;
`endif

    assign bird_y  = r_bird_y;
    assign vel     = r_vel;
    assign touched = r_touched;
    assign flying  = (r_state == S_FLY);

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath: launch, flap, bounds, pipe collision, restart, reset and score.
module tb_bird_datapath;
    logic       clk = 1'b0;
    logic       reset, start, raise, tick;
    logic [7:0] pipe_x;
    logic [6:0] gap_y;
    logic [6:0] bird_y;
    logic [4:0] vel;
    logic       touched, flying;
    logic [7:0] score;
    int         total = 0;
    int         bad = 0;

    bird_datapath dut (
        .clk(clk), .reset(reset), .start(start), .raise(raise), .tick(tick),
        .pipe_x(pipe_x), .gap_y(gap_y), .bird_y(bird_y), .vel(vel),
        .touched(touched), .flying(flying), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input logic r);
        @(negedge clk);
        raise = r;
        tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        raise = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; raise = 1'b0; tick = 1'b0;
        pipe_x = 8'd200; gap_y = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_y", bird_y, 60);
        check("rst_vel", $signed(vel), 0);
        check("rst_touched", touched, 0);
        check("rst_flying", flying, 0);
        check("rst_score", score, 0);

        // tick in idle is ignored
        do_tick(1'b0);
        check("idle_tick_y", bird_y, 60);
        check("idle_tick_flying", flying, 0);

        // 1: fall under gravity
        do_start();
        check("start_flying", flying, 1);
        do_tick(1'b0);
        check("t1_vel", $signed(vel), 1);
        check("t1_y", bird_y, 61);
        do_tick(1'b0);
        check("t2_vel", $signed(vel), 2);
        check("t2_y", bird_y, 63);
        check("t2_touched", touched, 0);
        check("t2_flying", flying, 1);

        // 2: flap then gravity
        do_tick(1'b1);
        check("flap_vel", $signed(vel), -4);
        check("flap_y", bird_y, 59);
        do_tick(1'b0);
        check("after_flap_vel", $signed(vel), -3);
        check("after_flap_y", bird_y, 56);

        // 3: climb into the ceiling
        do_start();
        for (int i = 0; i < 14; i++) do_tick(1'b1);
        check("climb14_y", bird_y, 4);
        check("climb14_touched", touched, 0);
        do_tick(1'b1);
        check("ceil_y", bird_y, 0);
        check("ceil_touched", touched, 1);
        check("ceil_vel", $signed(vel), -4);
        check("ceil_flying", flying, 0);
        do_tick(1'b1);
        do_tick(1'b0);
        check("hit_hold_y", bird_y, 0);
        check("hit_hold_touched", touched, 1);

        // 5a: restart out of the hit state
        do_start();
        check("restart_touched", touched, 0);
        check("restart_y", bird_y, 60);
        check("restart_vel", $signed(vel), 0);
        check("restart_flying", flying, 1);

        // floor: clamps to 116 on the 12th gravity tick
        for (int i = 0; i < 11; i++) do_tick(1'b0);
        check("fall11_y", bird_y, 111);
        check("fall11_vel", $signed(vel), 6);
        check("fall11_touched", touched, 0);
        do_tick(1'b0);
        check("floor_y", bird_y, 116);
        check("floor_touched", touched, 1);

        // 4: pipe overlap, gap above the bird -> hit; gap around the bird -> clear
        pipe_x = 8'd38; gap_y = 7'd10;
        do_start();
        do_tick(1'b0);
        check("pipe_hit_touched", touched, 1);
        check("pipe_hit_y", bird_y, 61);
        gap_y = 7'd50;
        do_start();
        do_tick(1'b0);
        check("pipe_clear_touched", touched, 0);
        check("pipe_clear_flying", flying, 1);

        // 5b: start and tick together -> reload, no motion
        @(negedge clk);
        start = 1'b1; tick = 1'b1;
        @(negedge clk);
        start = 1'b0; tick = 1'b0;
        check("start_tick_y", bird_y, 60);
        check("start_tick_vel", $signed(vel), 0);

        // 5c: reset mid-flight
        pipe_x = 8'd200;
        do_tick(1'b0);
        do_tick(1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_y", bird_y, 60);
        check("midrst_vel", $signed(vel), 0);
        check("midrst_touched", touched, 0);
        check("midrst_flying", flying, 0);

        // 6: approaching pipe with the bird hovering inside the gap
        gap_y = 7'd40;
        do_start();
        for (int i = 0; i < 28; i++) begin
            pipe_x = 8'(60 - i);
            do_tick(bird_y > 7'd60);
        end
        check("score_before", score, 0);
        check("hover_touched", touched, 0);
        pipe_x = 8'd32;
        do_tick(bird_y > 7'd60);
        check("hover_flying", flying, 1);
`ifdef BIRD_SCORE_EN
        check("score_pass", score, 1);
`else
        check("score_pass", score, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
